// File: rtl/mips_cpu_muldiv_ctrl.sv
// ============================================================================
// Module   : mips_cpu_muldiv_ctrl
// Brief    : HI/LO owner; iterative 1-bit/cycle MULT(U)/DIV(U), MTHI/MTLO and
//            MFHI/MFLO stall interlock. Optional MULDIV_FAST_MUL_EN macro
//            selects a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_cpu_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            op_ready,
    output logic            busy,
    input  logic            rd_req,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t              state_q;
    logic [4:0]          cnt_q;
    logic                is_div_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [XLEN-1:0]     opa_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;

    logic                signed_op;
    logic [XLEN-1:0]     rs_mag;
    logic [XLEN-1:0]     rt_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   acc_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign rs_mag    = (signed_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
    assign rt_mag    = (signed_op && rt_val[XLEN-1]) ? -rt_val : rt_val;

    assign op_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign stall     = rd_req & busy;
    assign hi        = hi_q;
    assign lo        = lo_q;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    logic [2*XLEN-1:0] fast_prod_u;
    assign fast_prod_s = $signed({{XLEN{rs_val[XLEN-1]}}, rs_val})
                       * $signed({{XLEN{rt_val[XLEN-1]}}, rt_val});
    assign fast_prod_u = {{XLEN{1'b0}}, rs_val} * {{XLEN{1'b0}}, rt_val};
`endif

    // Multiply keeps the multiplier in acc[31:0] and shifts right; divide keeps
    // the partial remainder in acc[63:32] and shifts the dividend/quotient left.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        trial    = rem_sh - {1'b0, opa_q};
        if (is_div_q) begin
            if (trial[XLEN])
                acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fix = neg_quo_q ? -acc_q : acc_q;
        quo_fix  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opa_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            OP_DIV, OP_DIVU: begin
                                state_q   <= S_RUN;
                                cnt_q     <= '0;
                                is_div_q  <= 1'b1;
                                opa_q     <= rt_mag;
                                acc_q     <= {{XLEN{1'b0}}, rs_mag};
                                neg_quo_q <= signed_op & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                                neg_rem_q <= signed_op & rs_val[XLEN-1];
                            end
`ifdef MULDIV_FAST_MUL_EN
                            OP_MULT:  {hi_q, lo_q} <= fast_prod_s;
                            OP_MULTU: {hi_q, lo_q} <= fast_prod_u;
`else
                            OP_MULT, OP_MULTU: begin
                                state_q   <= S_RUN;
                                cnt_q     <= '0;
                                is_div_q  <= 1'b0;
                                opa_q     <= rs_mag;
                                acc_q     <= {{XLEN{1'b0}}, rt_mag};
                                neg_quo_q <= signed_op & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                                neg_rem_q <= 1'b0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mips_cpu_muldiv_ctrl.md
# mips_cpu_muldiv_ctrl

Sequencer owning the HI/LO special registers of the MIPS CPU. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the decode stage and runs multiply and divide iteratively, one bit per cycle. It presents HI/LO for MFHI/MFLO and raises a stall when a HI/LO read collides with an operation in flight.

## Interface
Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  request present from decode.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are accepted as no-ops.
- rs_val  in  32  GPR rs (multiplicand / dividend / MTHI-MTLO source).
- rt_val  in  32  GPR rt (multiplier / divisor).
- op_ready  out  1  high when the block accepts a request this cycle.
- busy  out  1  multiply/divide in flight.
- rd_req  in  1  decode holds MFHI or MFLO this cycle.
- stall  out  1  rd_req & busy; the CPU freezes fetch/decode while high.
- hi  out  32  HI register, combinational read.
- lo  out  32  LO register, combinational read.

## Operation
- States: IDLE, RUN, FIX.
- op_ready = (state==IDLE).
- A request is accepted at a rising edge where op_valid & op_ready. rs_val and rt_val are latched at that edge.
- MTHI/MTLO: HI (resp. LO) <= rs_val at the accept edge. The other register is unchanged. State stays IDLE.
- MULT/DIV (signed): magnitudes are latched, plus neg_q = sign(rs)^sign(rt) and neg_r = sign(rs). MULTU/DIVU: raw values are latched, with both negate flags at 0.
- RUN: a 5-bit counter runs 0..31, processing one bit per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 33-bit partial remainder.
- RUN->FIX when the counter reaches 31.
- FIX: sign correction is applied, then HI/LO are written and the state returns to IDLE.
  - Multiply: {HI,LO} = neg_q ? -prod : prod.
  - Divide: LO = neg_q ? -quot : quot; HI = neg_r ? -rem : rem.
- Divide by zero produces no trap; the unrolled algorithm result is kept:
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV x/0: HI=x, LO = x<0 ? 0x00000001 : 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Requests presented while busy are not accepted. The requester holds op_valid, op and operands until op_ready.
- stall is purely combinational. HI/LO are never partially updated; they change only at the FIX->IDLE edge or an MTHI/MTLO accept.

## Timing
- Reset: state=IDLE, counter=0, hi=0, lo=0, busy=0, op_ready=1, stall=0. Reset mid-operation aborts the operation, discards the accumulator and zeroes HI/LO at that edge.
- Multiply/divide latency, with the accept edge as E0:
  - busy is high in the 33 cycles between E0 and E33 (32 RUN + 1 FIX).
  - HI/LO hold new values after E33.
  - op_ready is high again in the cycle after E33, so back-to-back operations start every 34 cycles.
- MTHI/MTLO latency is 1 edge. An MFHI issued in the next cycle reads the new value.
- MFHI/MFLO during busy: stall high every cycle through the FIX cycle. After E33, stall drops and hi/lo already show the result.
- No accept is possible while busy, so a simultaneous MTHI and FIX write never occurs.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle 32x32 multiplier and write {HI,LO} at the accept edge E0.
  - State stays IDLE and busy never rises for multiply.
  - Divide is unchanged.
- MULDIV_FAST_MUL_EN undefined: multiply uses the 33-cycle iterative path described above.

## Test plan
- Reset then MTHI rs=0x12345678 -> hi=0x12345678 after 1 edge, lo=0, busy=0 throughout.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA. With the macro defined, both complete in 1 edge and busy stays 0.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Divide by zero: DIVU 0x55/0 -> lo=0xFFFFFFFF, hi=0x55. DIV 0xFFFFFFF0/0 -> lo=1, hi=0xFFFFFFF0. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interlock: start DIV, assert rd_req from cycle 2, and present MTLO 0xAA with op_valid held.
  - stall is high until E33 and op_ready stays low.
  - The MTLO is accepted at E34, giving lo=0xAA and hi = divide remainder.
- Reset asserted at RUN counter=10 of a MULTU -> next cycle state IDLE, hi=lo=0, busy=0. A following MULTU 3*5 gives lo=15, hi=0.
